game_tick_sel: RTL and testbench
================================

# game_tick_sel

Downstream consumer of the game-speed clock dividers. It takes the three divided clocks (slow/mid/fast) as asynchronous level inputs and synchronizes each into the system `clk` domain. It converts them to single-cycle tick enables and forwards the tick of the currently selected speed level to game logic. A small run-control FSM (idle/run/paused/over) gates ticks and raises the level automatically after a programmable number of ticks.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops per divided-clock input (min 2).
- `LEVEL_UP_TICKS`, 64: ticks at one level before auto level-up (min 1).
- `CNT_W`, 16: width of `tick_count`.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous assert, active-low.
- `div_clk_slow`, in, 1: slow divided clock, async to `clk`, level 0.
- `div_clk_mid`, in, 1: mid divided clock, async, level 1.
- `div_clk_fast`, in, 1: fast divided clock, async, level 2.
- `start`, in, 1: sync pulse; start/restart game.
- `pause`, in, 1: sync pulse; toggle RUN/PAUSED.
- `game_over`, in, 1: sync pulse; end game.
- `tick`, out, 1: registered one-cycle game-step enable.
- `level`, out, 2: current speed level 0..2.
- `tick_count`, out, CNT_W: ticks issued since start, saturating.
- `running`, out, 1: high in RUN.

## Operation
- Per input: SYNC_STAGES-flop synchronizer, then rising-edge detect `e = s & ~s_prev`. All three detectors run in every state, so level changes never produce a spurious edge.
- Selected edge: `sel_e` = edge of source indexed by `level`.
- FSM states: IDLE, RUN, PAUSED, OVER.
  - IDLE: `start` -> RUN. `pause`/`game_over` ignored.
  - RUN: `game_over` -> OVER. Otherwise `pause` -> PAUSED. `start` ignored.
  - PAUSED: `game_over` -> OVER. Otherwise `pause` -> RUN. `start` ignored.
  - OVER: `start` -> RUN. Others ignored.
- Priority in one cycle: `game_over` > `pause`. `start` is only acted on in IDLE/OVER.
- Entering RUN from IDLE/OVER clears `level`, `tick_count` and the internal `lvl_ticks` counter. Resume from PAUSED preserves all of them.
- `tick` = 1 for one cycle iff state is RUN and `sel_e`. Edges arriving in other states are dropped, not queued.
- On each issued tick:
  - `tick_count` += 1, saturating at 2^CNT_W−1.
  - `lvl_ticks` += 1. When `lvl_ticks` reaches LEVEL_UP_TICKS−1 and a tick issues, `lvl_ticks` returns to 0 and `level` increments, saturating at 2.
  - At level 2, `lvl_ticks` keeps wrapping with no further effect.
- `lvl_ticks` width: $clog2(LEVEL_UP_TICKS)+1.

## Timing
- Reset values: `tick`=0, `level`=0, `tick_count`=0, `running`=0, state IDLE, all synchronizer and edge flops 0.
- Latency (SYNC_STAGES=2): input rises before clk edge k; sync1 at k, sync2 at k+1, `tick` registered high after edge k+2, for exactly one cycle.
- Each rising input edge yields at most one tick. The divided-clock high and low phases are each ≥ SYNC_STAGES+1 clk periods (guaranteed by the dividers).
- The `level` update is registered with the tick that causes it. The next tick uses the new source.
- `running` updates the cycle after the transition-causing pulse.
- Edge in the same cycle as `pause` entering PAUSED: FSM uses its current state, so the tick still issues. Edge in the same cycle as `game_over`: tick still issues, then OVER.
- Reset mid-game: all outputs return to reset values immediately (async). First tick only after a new `start`.

## Structure
- Shared package `game_pkg`:
  - `game_state_t` enum (IDLE, RUN, PAUSED, OVER).
  - Level constants LVL_SLOW=0, LVL_MID=1, LVL_FAST=2.
  - LVL_MAX=2.
- Sub-module `sync_edge_det`:
  - Parameter SYNC_STAGES; ports `clk`, `rst_n`, `d_async`, `rise`.
  - Instantiated three times.
- The top level holds the FSM, mux and counters.

## Test plan
Bench uses LEVEL_UP_TICKS=4, CNT_W=4, divided clocks with periods 40/20/10 clk.
1. Reset with inputs toggling -> no `tick`, `level`=0, `running`=0. `start` -> `running`=1 next cycle; first slow rising edge -> `tick` 3 cycles later, width 1.
2. Run 4 ticks -> `level`=1 with 4th tick, next ticks at 20-clk spacing. 4 more -> `level`=2. 8 more -> `level` stays 2.
3. `pause` -> slow edges yield no tick, count frozen. `pause` again -> ticks resume, `level`/`tick_count` unchanged.
4. Run past 15 ticks -> `tick_count` holds 15 while `tick` continues.
5. `game_over` and `pause` in the same cycle -> OVER, no ticks. `start` -> RUN with `level`=0, `tick_count`=0.
6. Assert `rst_n` low between sync2 and the tick register -> no tick, all outputs 0. Release -> IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game run-control logic.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    localparam logic [1:0] LVL_SLOW = 2'd0;
    localparam logic [1:0] LVL_MID  = 2'd1;
    localparam logic [1:0] LVL_FAST = 2'd2;
    localparam logic [1:0] LVL_MAX  = 2'd2;

    // Speed level steps up by one and sticks at the fastest setting.
    function automatic logic [1:0] next_level(input logic [1:0] lvl);
        return (lvl >= LVL_MAX) ? LVL_MAX : lvl + 2'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_prev;

    // NOTE: state flops use non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            s_prev <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], d_async};
            s_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~s_prev;

endmodule

// File: rtl/game_tick_sel.sv
// Turns the three divided game clocks into a single gated tick enable and runs the
// idle/run/paused/over control with automatic level-up.
module game_tick_sel
    import game_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int LEVEL_UP_TICKS = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk_slow,
    input  logic             div_clk_mid,
    input  logic             div_clk_fast,
    input  logic             start,
    input  logic             pause,
    input  logic             game_over,
    output logic             tick,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] tick_count,
    output logic             running
);

    localparam int              LT_W    = $clog2(LEVEL_UP_TICKS) + 1;
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LEVEL_UP_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]      rise;
    logic            sel_e;
    logic            issue;
    logic            restart;
    logic [LT_W-1:0] lvl_ticks;
    game_state_t     state;
    game_state_t     state_nxt;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_slow (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (div_clk_slow),
        .rise    (rise[LVL_SLOW])
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mid (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (div_clk_mid),
        .rise    (rise[LVL_MID])
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fast (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (div_clk_fast),
        .rise    (rise[LVL_FAST])
    );

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        sel_e = 1'b0;
        case (level)
            LVL_SLOW: sel_e = rise[LVL_SLOW];
            LVL_MID:  sel_e = rise[LVL_MID];
            LVL_FAST: sel_e = rise[LVL_FAST];
            default:  sel_e = 1'b0;
        endcase
    end

    // game_over wins over pause; start only matters when no game is in progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (game_over) state_nxt = OVER;
                     else if (pause) state_nxt = PAUSED;
            PAUSED:  if (game_over) state_nxt = OVER;
                     else if (pause) state_nxt = RUN;
            OVER:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign restart = start && ((state == IDLE) || (state == OVER));
    assign issue   = (state == RUN) && sel_e;
    assign running = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // restart and issue are mutually exclusive: one needs IDLE/OVER, the other RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick       <= 1'b0;
            level      <= LVL_SLOW;
            tick_count <= '0;
            lvl_ticks  <= '0;
        end else begin
            tick <= issue;
            if (restart) begin
                level      <= LVL_SLOW;
                tick_count <= '0;
                lvl_ticks  <= '0;
            end else if (issue) begin
                if (tick_count != CNT_MAX) begin
                    tick_count <= tick_count + 1'b1;
                end
                if (lvl_ticks == LT_LAST) begin
                    lvl_ticks <= '0;
                    level     <= next_level(level);
                end else begin
                    lvl_ticks <= lvl_ticks + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_tick_sel.sv
// Self-checking bench for game_tick_sel: randomized divider phases and control pulses
// compared against a cycle-level behavioural model.
module tb_game_tick_sel;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_OVER = 3;
    localparam int LUT    = 4;
    localparam int CMAX   = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div_clk_slow = 1'b0;
    logic       div_clk_mid = 1'b0;
    logic       div_clk_fast = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       game_over = 1'b0;
    logic       tick;
    logic [1:0] level;
    logic [3:0] tick_count;
    logic       running;
    logic [7:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // model state
    int m_state, m_level, m_count, m_lvl, m_since;
    bit m_tick;
    bit m_prev[3];
    int m_due[3];

    game_tick_sel #(
        .SYNC_STAGES    (2),
        .LEVEL_UP_TICKS (LUT),
        .CNT_W          (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_clk_slow (div_clk_slow),
        .div_clk_mid  (div_clk_mid),
        .div_clk_fast (div_clk_fast),
        .start        (start),
        .pause        (pause),
        .game_over    (game_over),
        .tick         (tick),
        .level        (level),
        .tick_count   (tick_count),
        .running      (running)
    );

    assign dut_vec = {tick, level, tick_count, running};

    always #5 clk = ~clk;

    // Divided clocks: periods 40/20/10 clk, random phase, edges never on a clk edge.
    initial begin
        #($urandom_range(0, 79) * 5 + 2);
        forever #200 div_clk_slow = ~div_clk_slow;
    end
    initial begin
        #($urandom_range(0, 39) * 5 + 2);
        forever #100 div_clk_mid = ~div_clk_mid;
    end
    initial begin
        #($urandom_range(0, 19) * 5 + 2);
        forever #50 div_clk_fast = ~div_clk_fast;
    end

    initial forever begin
        @(negedge clk);
        cyc++;
    end

    function automatic logic [7:0] exp_vec();
        logic [1:0] l;
        logic [3:0] c;
        l = 2'(m_level);
        c = 4'(m_count);
        return {m_tick, l, c, m_state == M_RUN};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_level = 0;
        m_count = 0;
        m_lvl   = 0;
        m_since = 0;
        m_tick  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 1'b0;
            m_due[i]  = 0;
        end
    endtask

    // One clk edge: an input rise first seen at edge k becomes a usable edge at edge k+2.
    task automatic model_step();
        bit v[3];
        bit fire[3];
        bit issue;
        v[0] = div_clk_slow;
        v[1] = div_clk_mid;
        v[2] = div_clk_fast;
        for (int i = 0; i < 3; i++) begin
            fire[i] = 1'b0;
            if (m_due[i] > 0) begin
                m_due[i]--;
                if (m_due[i] == 0) fire[i] = 1'b1;
            end
            if (v[i] && !m_prev[i]) m_due[i] = 2;
            m_prev[i] = v[i];
        end
        issue  = (m_state == M_RUN) && fire[m_level];
        m_tick = issue;
        if (issue) begin
            m_since++;
            if (m_count < CMAX) m_count++;
            m_lvl++;
            if (m_lvl == LUT) begin
                m_lvl = 0;
                if (m_level < 2) m_level++;
            end
        end
        case (m_state)
            M_IDLE, M_OVER: if (start) begin
                m_state = M_RUN;
                m_level = 0;
                m_count = 0;
                m_lvl   = 0;
                m_since = 0;
            end
            M_RUN:    if (game_over) m_state = M_OVER; else if (pause) m_state = M_PAUSED;
            M_PAUSED: if (game_over) m_state = M_OVER; else if (pause) m_state = M_RUN;
            default:  m_state = M_IDLE;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic pulse(input bit s, input bit p, input bit g);
        start     = s;
        pause     = p;
        game_over = g;
        @(negedge clk);
        start     = 1'b0;
        pause     = 1'b0;
        game_over = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        start = 1'b1;
        pause = 1'b1;
        repeat (30) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_hold: got %b expected %b", dut_vec, 8'h00);
            end
        end
        start = 1'b0;
        pause = 1'b0;
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec() || tick !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_after_reset: got %b expected %b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_start();
        bit p;
        bit found;
        bit exp_t[4];
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b0};
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL start_running: got %b expected running=1 vec %b", dut_vec, exp_vec());
        end
        @(posedge clk);
        p = div_clk_slow;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            if (div_clk_slow && !p) found = 1'b1;
            p = div_clk_slow;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL slow_edge_timeout: got none expected a slow rising edge");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== exp_t[i] || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL first_tick_latency[%0d]: got tick=%b vec %b expected tick=%b vec %b",
                         i, tick, dut_vec, exp_t[i], exp_vec());
            end
        end
    endtask

    task automatic test_levels();
        int t5, t6;
        t5 = -1;
        t6 = -1;
        for (int i = 0; i < 3000 && m_since < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL levels_model: got %b expected %b", dut_vec, exp_vec());
            end
            if (m_tick && m_since == 4) begin
                n_cmp++;
                if (level !== 2'd1) begin
                    n_bad++;
                    $display("FAIL level_up_1: got %0d expected 1", level);
                end
            end
            if (m_tick && m_since == 8) begin
                n_cmp++;
                if (level !== 2'd2) begin
                    n_bad++;
                    $display("FAIL level_up_2: got %0d expected 2", level);
                end
            end
            if (tick === 1'b1 && m_since == 5) t5 = cyc;
            if (tick === 1'b1 && m_since == 6) t6 = cyc;
        end
        n_cmp++;
        if (m_since < 10 || t6 - t5 != 20) begin
            n_bad++;
            $display("FAIL mid_spacing: got ticks=%0d spacing=%0d expected ticks>=10 spacing=20",
                     m_since, t6 - t5);
        end
    endtask

    task automatic test_pause();
        int fr_count, fr_level;
        bit seen;
        pulse(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        fr_count = m_count;
        fr_level = m_level;
        repeat (120) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== 1'b0 || running !== 1'b0 || tick_count !== 4'(fr_count)
                || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL paused: got %b expected tick=0 running=0 count=%0d", dut_vec, fr_count);
            end
        end
        pulse(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (running !== 1'b1 || level !== 2'(fr_level) || tick_count !== 4'(fr_count)) begin
            n_bad++;
            $display("FAIL resume: got %b expected running=1 level=%0d count=%0d",
                     dut_vec, fr_level, fr_count);
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL resume_model: got %b expected %b", dut_vec, exp_vec());
            end
            if (tick === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || tick_count !== 4'(fr_count + 1)) begin
            n_bad++;
            $display("FAIL resume_tick: got seen=%b count=%0d expected seen=1 count=%0d",
                     seen, tick_count, fr_count + 1);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3000 && m_since < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL saturate_model: got %b expected %b", dut_vec, exp_vec());
            end
            if (m_tick && m_since >= 16) begin
                n_cmp++;
                if (tick !== 1'b1 || tick_count !== 4'd15 || level !== 2'd2) begin
                    n_bad++;
                    $display("FAIL saturate: got tick=%b count=%0d level=%0d expected 1/15/2",
                             tick, tick_count, level);
                end
            end
        end
    endtask

    task automatic test_over();
        pulse(1'b0, 1'b1, 1'b1);
        repeat (80) begin
            @(negedge clk);
            n_cmp++;
            if (running !== 1'b0 || tick !== 1'b0 || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL over: got %b expected running=0 tick=0 vec %b", dut_vec, exp_vec());
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b1 || level !== 2'd0 || tick_count !== 4'd0) begin
            n_bad++;
            $display("FAIL restart: got %b expected running=1 level=0 count=0", dut_vec);
        end
        repeat (100) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL restart_model: got %b expected %b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit armed;
        armed = 1'b0;
        for (int i = 0; i < 400 && !armed; i++) begin
            @(negedge clk);
            if (m_state == M_RUN && m_due[m_level] == 1) armed = 1'b1;
        end
        n_cmp++;
        if (!armed) begin
            n_bad++;
            $display("FAIL reset_mid_arm: got no pending edge expected one");
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %b expected %b", dut_vec, 8'h00);
        end
        @(negedge clk);
        n_cmp++;
        if (dut_vec !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_no_tick: got %b expected %b", dut_vec, 8'h00);
        end
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== 1'b0 || running !== 1'b0 || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_mid_idle: got %b expected %b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        repeat (2000) begin
            start     = ($urandom_range(0, 59) == 0);
            pause     = ($urandom_range(0, 39) == 0);
            game_over = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random: got %b expected %b", dut_vec, exp_vec());
            end
        end
        start     = 1'b0;
        pause     = 1'b0;
        game_over = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_levels();
        test_pause();
        test_saturate();
        test_over();
        test_reset_mid();
        pulse(1'b1, 1'b0, 1'b0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
